// File: rtl/bench_pkg.sv
// bench_pkg: shared FSM type, condition constants, defaults and the
// saturating adder used by the benchmark sequencer.
package bench_pkg;

  localparam int NUM_COND    = 4;
  localparam int COND_W      = 2;
  localparam int ITERS_DEF   = 16;
  localparam int TIMEOUT_DEF = 1048576;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_LAUNCH = 3'd2,
    ST_WAIT   = 3'd3,
    ST_NEXT   = 3'd4,
    ST_SCAN   = 3'd5,
    ST_FINISH = 3'd6
  } state_e;

  // Add a and b, clamping at 2^w-1 instead of wrapping (w in 1..63).
  function automatic logic [63:0] sat_add(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input int unsigned w);
    logic [64:0] sum;
    logic [63:0] max;
    max = (64'd1 << w) - 64'd1;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, max}) begin
      sat_add = max;
    end else begin
      sat_add = sum[63:0];
    end
  endfunction

endpackage

// File: rtl/bench_sequencer_if.sv
// bench_sequencer_if: start/done handshake and condition select between the
// sequencer (master) and the router under test (slave).
interface bench_sequencer_if;
  import bench_pkg::*;

  logic              dut_start;
  logic              dut_done;
  logic [COND_W-1:0] dut_cond;

  modport master (output dut_start, output dut_cond, input dut_done);
  modport slave  (input dut_start, input dut_cond, output dut_done);
endinterface

// File: rtl/bench_argmin.sv
// bench_argmin: walks NUM_COND values one per cycle after start_i and reports
// the index of the smallest as a one-hot vector. Strict less-than keeps the
// lowest index on ties. Excluded entries rank above every included value.
module bench_argmin
  import bench_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start_i,
  input  logic [NUM_COND-1:0][CNT_W-1:0]    vals_i,
  input  logic [NUM_COND-1:0]               excl_i,
  output logic [NUM_COND-1:0]               onehot_o,
  output logic                              valid_o
);

  logic              run_q, run_d;
  logic [COND_W-1:0] idx_q, idx_d;
  logic [COND_W-1:0] bidx_q, bidx_d;
  logic [CNT_W:0]    best_q, best_d;
  logic [CNT_W:0]    key_s;
  logic              take_s;
  logic [COND_W-1:0] win_s;

  // Compare the current entry against the best so far and advance the walk.
  always_comb begin
    key_s    = {excl_i[idx_q], vals_i[idx_q]};
    take_s   = (idx_q == COND_W'(0)) || (key_s < best_q);
    if (take_s) begin
      win_s = idx_q;
    end else begin
      win_s = bidx_q;
    end
    valid_o  = run_q && (idx_q == COND_W'(NUM_COND - 1));
    onehot_o = NUM_COND'(1) << win_s;

    run_d  = run_q;
    idx_d  = idx_q;
    bidx_d = bidx_q;
    best_d = best_q;
    if (start_i) begin
      run_d = 1'b1;
      idx_d = COND_W'(0);
    end else if (run_q) begin
      idx_d  = idx_q + COND_W'(1);
      bidx_d = win_s;
      if (take_s) begin
        best_d = key_s;
      end else begin
        best_d = best_q;
      end
      if (valid_o) begin
        run_d = 1'b0;
      end else begin
        run_d = 1'b1;
      end
    end else begin
      run_d = 1'b0;
    end
  end

  // Walk state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q  <= 1'b0;
      idx_q  <= '0;
      bidx_q <= '0;
      best_q <= '0;
    end else begin
      run_q  <= run_d;
      idx_q  <= idx_d;
      bidx_q <= bidx_d;
      best_q <= best_d;
    end
  end

endmodule

// File: rtl/bench_sequencer.sv
// bench_sequencer: steps the router through NUM_COND conditions, ITERS
// start/done iterations each, accumulates cycles per condition and lights the
// LED of the fastest one. Optional per-iteration watchdog: BENCH_TIMEOUT_EN.
module bench_sequencer
  import bench_pkg::*;
#(
  parameter int ITERS   = ITERS_DEF,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  bench_sequencer_if.master     dut_if,
  output logic                  busy,
  output logic                  done,
  output logic [NUM_COND-1:0]   led_onehot,
  output logic [CNT_W-1:0]      t_cond0,
  output logic [CNT_W-1:0]      t_cond1,
  output logic [CNT_W-1:0]      t_cond2,
  output logic [CNT_W-1:0]      t_cond3,
  output logic                  timeout_err
);

  localparam logic [15:0]       LAST_ITER = 16'(ITERS - 1);
  localparam logic [COND_W-1:0] LAST_COND = COND_W'(NUM_COND - 1);

  state_e                         state_q, state_d;
  logic                           busy_q, busy_d;
  logic                           done_q, done_d;
  logic                           dstart_q, dstart_d;
  logic [COND_W-1:0]              cond_q, cond_d;
  logic [15:0]                    iter_q, iter_d;
  logic [NUM_COND-1:0][CNT_W-1:0] acc_q, acc_d;
  logic [NUM_COND-1:0]            led_q, led_d;
  logic [NUM_COND-1:0]            tmo_q, tmo_d;
  logic                           scan_start_s;
  logic                           scan_valid_s;
  logic [NUM_COND-1:0]            scan_onehot_s;
  logic                           wd_hit_s;

`ifdef BENCH_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            terr_q, terr_d;

  assign wd_hit_s    = (wd_q == WD_W'(TIMEOUT - 1));
  assign timeout_err = terr_q;

  // Watchdog: counts WAIT cycles of the current iteration; error is sticky.
  always_comb begin
    wd_d   = wd_q;
    terr_d = terr_q;
    if (state_q == ST_CLEAR) begin
      wd_d   = '0;
      terr_d = 1'b0;
    end else if (state_q == ST_LAUNCH) begin
      wd_d = '0;
    end else if (state_q == ST_WAIT) begin
      wd_d = wd_q + WD_W'(1);
      if (wd_hit_s && !dut_if.dut_done) begin
        terr_d = 1'b1;
      end else begin
        terr_d = terr_q;
      end
    end else begin
      wd_d = wd_q;
    end
  end

  // Watchdog registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q   <= '0;
      terr_q <= 1'b0;
    end else begin
      wd_q   <= wd_d;
      terr_q <= terr_d;
    end
  end
`else
  // No watchdog in this build: the limit is inert and the flag stays low.
  localparam logic TERR_TIE = 1'b0 & (TIMEOUT > 0);
  assign wd_hit_s    = 1'b0;
  assign timeout_err = TERR_TIE;
`endif

  assign scan_start_s = (state_q == ST_NEXT) && (cond_q == LAST_COND);

  bench_argmin #(.CNT_W(CNT_W)) u_argmin (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (scan_start_s),
    .vals_i   (acc_q),
    .excl_i   (tmo_q),
    .onehot_o (scan_onehot_s),
    .valid_o  (scan_valid_s)
  );

  // Next-state logic plus the registered-output values derived from it.
  always_comb begin
    state_d = state_q;
    cond_d  = cond_q;
    iter_d  = iter_q;
    acc_d   = acc_q;
    led_d   = led_q;
    tmo_d   = tmo_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_CLEAR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        cond_d  = '0;
        iter_d  = 16'd0;
        acc_d   = '0;
        led_d   = '0;
        tmo_d   = '0;
        state_d = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        acc_d[cond_q] = CNT_W'(sat_add(64'(acc_q[cond_q]), 64'd1, CNT_W));
        if (dut_if.dut_done) begin
          iter_d = iter_q + 16'd1;
          if (iter_q == LAST_ITER) begin
            state_d = ST_NEXT;
          end else begin
            state_d = ST_LAUNCH;
          end
        end else if (wd_hit_s) begin
          // Abandon this condition; all-ones marks it as timed out.
          acc_d[cond_q] = '1;
          tmo_d[cond_q] = 1'b1;
          state_d       = ST_NEXT;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_NEXT: begin
        if (cond_q == LAST_COND) begin
          state_d = ST_SCAN;
        end else begin
          cond_d  = cond_q + COND_W'(1);
          iter_d  = 16'd0;
          state_d = ST_LAUNCH;
        end
      end
      ST_SCAN: begin
        if (scan_valid_s) begin
          led_d   = scan_onehot_s;
          state_d = ST_FINISH;
        end else begin
          state_d = ST_SCAN;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d   = (state_d != ST_IDLE) && (state_d != ST_FINISH);
    done_d   = (state_d == ST_FINISH);
    dstart_d = (state_d == ST_LAUNCH);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dstart_q <= 1'b0;
      cond_q   <= '0;
      iter_q   <= 16'd0;
      acc_q    <= '0;
      led_q    <= '0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dstart_q <= dstart_d;
      cond_q   <= cond_d;
      iter_q   <= iter_d;
      acc_q    <= acc_d;
      led_q    <= led_d;
      tmo_q    <= tmo_d;
    end
  end

  assign dut_if.dut_start = dstart_q;
  assign dut_if.dut_cond  = cond_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign led_onehot       = led_q;
  assign t_cond0          = acc_q[0];
  assign t_cond1          = acc_q[1];
  assign t_cond2          = acc_q[2];
  assign t_cond3          = acc_q[3];

endmodule

// File: tb/tb_bench_sequencer.sv
// tb_bench_sequencer: directed and randomized benchmark runs against a
// behavioural model (per-condition latency -> totals, winner, run length).
`timescale 1ns/1ps
module tb_bench_sequencer;
  import bench_pkg::*;

  localparam int ITERS = 2;
  localparam int TMO   = 64;
  localparam int CW    = 32;
  localparam int SW    = 5;

  logic clk = 1'b0;
  logic rst_n;
  logic start_m, start_s;
  logic busy_m, done_m, terr_m, busy_s, done_s, terr_s;
  logic [3:0] led_m, led_s;
  logic [CW-1:0] tm0, tm1, tm2, tm3;
  logic [SW-1:0] ts0, ts1, ts2, ts3;

  int n_chk = 0;
  int n_fail = 0;
  int lat_m[4];
  int lat_s[4];
  int rem_m = 0;
  int rem_s = 0;
  bit glitch = 1'b0;
  int n_launch_m = 0;

  always #4 clk = ~clk;

  bench_sequencer_if dif_m ();
  bench_sequencer_if dif_s ();

  bench_sequencer #(.ITERS(ITERS), .CNT_W(CW), .TIMEOUT(TMO)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start_m), .dut_if(dif_m),
    .busy(busy_m), .done(done_m), .led_onehot(led_m),
    .t_cond0(tm0), .t_cond1(tm1), .t_cond2(tm2), .t_cond3(tm3),
    .timeout_err(terr_m)
  );

  bench_sequencer #(.ITERS(ITERS), .CNT_W(SW), .TIMEOUT(TMO)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start_s), .dut_if(dif_s),
    .busy(busy_s), .done(done_s), .led_onehot(led_s),
    .t_cond0(ts0), .t_cond1(ts1), .t_cond2(ts2), .t_cond3(ts3),
    .timeout_err(terr_s)
  );

  // Router stand-in for the main DUT: answers lat cycles after dut_start
  // (0 = never); optional spurious dut_done during the launch cycle.
  always @(negedge clk) begin : resp_m
    logic dd;
    dd = 1'b0;
    if (!rst_n) begin
      rem_m = 0;
    end else begin
      if (rem_m > 0) begin
        rem_m--;
        if (rem_m == 0) dd = 1'b1;
      end
      if (dif_m.dut_start) begin
        rem_m = lat_m[dif_m.dut_cond];
        if (glitch) dd = 1'b1;
      end
    end
    dif_m.dut_done = dd;
  end

  // Router stand-in for the narrow-counter instance.
  always @(negedge clk) begin : resp_s
    logic dd;
    dd = 1'b0;
    if (!rst_n) begin
      rem_s = 0;
    end else begin
      if (rem_s > 0) begin
        rem_s--;
        if (rem_s == 0) dd = 1'b1;
      end
      if (dif_s.dut_start) rem_s = lat_s[dif_s.dut_cond];
    end
    dif_s.dut_done = dd;
  end

  always @(posedge clk) if (dif_m.dut_start) n_launch_m++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Model: total = latency * ITERS clamped to 2^w-1; no answer -> all ones.
  function automatic logic [63:0] model_acc(input int lat, input int w);
    logic [63:0] mx;
    logic [63:0] total;
    mx = (64'd1 << w) - 64'd1;
    if (lat == 0) return mx;
    total = 64'(lat) * 64'(ITERS);
    return (total > mx) ? mx : total;
  endfunction

  // Model: fastest answering condition, lowest index on ties, else 0.
  function automatic logic [3:0] model_led(input int l[4], input int w);
    int best;
    logic [63:0] bv, v;
    best = -1;
    bv = 64'd0;
    for (int c = 0; c < 4; c++) begin
      if (l[c] != 0) begin
        v = model_acc(l[c], w);
        if (best < 0 || v < bv) begin
          best = c;
          bv = v;
        end
      end
    end
    if (best < 0) best = 0;
    return 4'b0001 << best;
  endfunction

  // Model: cycles from start sample to the done pulse.
  function automatic int model_cycles(input int l[4]);
    int s;
    s = 10;
    for (int c = 0; c < 4; c++) s += (l[c] == 0) ? (1 + TMO) : ITERS * (1 + l[c]);
    return s;
  endfunction

  function automatic int model_launches(input int l[4]);
    int s;
    s = 0;
    for (int c = 0; c < 4; c++) s += (l[c] == 0) ? 1 : ITERS;
    return s;
  endfunction

  task automatic check_reset_state(input string pfx);
    check({pfx, "_busy"}, 64'(busy_m), 64'd0);
    check({pfx, "_done"}, 64'(done_m), 64'd0);
    check({pfx, "_led"}, 64'(led_m), 64'd0);
    check({pfx, "_t0"}, 64'(tm0), 64'd0);
    check({pfx, "_t1"}, 64'(tm1), 64'd0);
    check({pfx, "_t2"}, 64'(tm2), 64'd0);
    check({pfx, "_t3"}, 64'(tm3), 64'd0);
    check({pfx, "_terr"}, 64'(terr_m), 64'd0);
    check({pfx, "_dut_start"}, 64'(dif_m.dut_start), 64'd0);
    check({pfx, "_dut_cond"}, 64'(dif_m.dut_cond), 64'd0);
  endtask

  task automatic run_main(input int l0, input int l1, input int l2, input int l3,
                          input bit glitch_en, input bit restart_en);
    int l[4];
    int cyc, extra, launches0;
    bit seen, exp_terr;
    logic [63:0] obs[4];
    l[0] = l0; l[1] = l1; l[2] = l2; l[3] = l3;
    for (int c = 0; c < 4; c++) lat_m[c] = l[c];
    glitch = glitch_en;
    launches0 = n_launch_m;
    @(negedge clk); start_m = 1'b1;
    @(negedge clk); start_m = 1'b0;
    check("busy_after_start", 64'(busy_m), 64'd1);
    @(negedge clk);
    check("first_launch", 64'(dif_m.dut_start), 64'd1);
    check("first_cond", 64'(dif_m.dut_cond), 64'd0);
    cyc = 2;
    seen = 1'b0;
    while (!seen && cyc < 3000) begin
      start_m = restart_en && (cyc == 6);
      @(negedge clk);
      cyc++;
      if (done_m) seen = 1'b1;
    end
    start_m = 1'b0;
    glitch = 1'b0;
    check("done_seen", 64'(seen), 64'd1);
    check("done_cycle", 64'(cyc), 64'(model_cycles(l)));
    check("busy_at_done", 64'(busy_m), 64'd0);
    obs[0] = 64'(tm0); obs[1] = 64'(tm1); obs[2] = 64'(tm2); obs[3] = 64'(tm3);
    for (int c = 0; c < 4; c++) check($sformatf("t_cond%0d", c), obs[c], model_acc(l[c], CW));
    check("led_onehot", 64'(led_m), 64'(model_led(l, CW)));
    exp_terr = 1'b0;
`ifdef BENCH_TIMEOUT_EN
    for (int c = 0; c < 4; c++) if (l[c] == 0) exp_terr = 1'b1;
`endif
    check("timeout_err", 64'(terr_m), 64'(exp_terr));
    check("launches", 64'(n_launch_m - launches0), 64'(model_launches(l)));
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (done_m) extra++;
    end
    check("done_once", 64'(extra), 64'd0);
    check("led_held", 64'(led_m), 64'(model_led(l, CW)));
  endtask

  task automatic run_sat(input int l0, input int l1, input int l2, input int l3);
    int l[4];
    int cyc;
    bit seen;
    l[0] = l0; l[1] = l1; l[2] = l2; l[3] = l3;
    for (int c = 0; c < 4; c++) lat_s[c] = l[c];
    @(negedge clk); start_s = 1'b1;
    @(negedge clk); start_s = 1'b0;
    cyc = 1;
    seen = 1'b0;
    while (!seen && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (done_s) seen = 1'b1;
    end
    check("sat_done_seen", 64'(seen), 64'd1);
    check("sat_done_cycle", 64'(cyc), 64'(model_cycles(l)));
    check("sat_t0", 64'(ts0), model_acc(l[0], SW));
    check("sat_t1", 64'(ts1), model_acc(l[1], SW));
    check("sat_t2", 64'(ts2), model_acc(l[2], SW));
    check("sat_t3", 64'(ts3), model_acc(l[3], SW));
    check("sat_led", 64'(led_s), 64'(model_led(l, SW)));
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0;
    start_m = 1'b0;
    start_s = 1'b0;
    for (int c = 0; c < 4; c++) begin
      lat_m[c] = 1;
      lat_s[c] = 1;
    end
    repeat (3) @(negedge clk);
    check_reset_state("rst");
    check("rst_sat_busy", 64'(busy_s), 64'd0);
    check("rst_sat_t0", 64'(ts0), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_no_busy", 64'(busy_m), 64'd0);

    // Distinct latencies: 10/6/14/18, cond1 wins.
    run_main(5, 3, 7, 9, 1'b0, 1'b0);
    // All equal: tie goes to cond0.
    run_main(4, 4, 4, 4, 1'b0, 1'b0);
    // Shortest latency and a tie between cond0, cond1, cond3.
    run_main(1, 1, 2, 1, 1'b0, 1'b0);
    // Spurious done during launch plus start while busy: no effect.
    run_main(5, 3, 7, 9, 1'b1, 1'b1);

    // Reset in the middle of the cond2 wait.
    for (int c = 0; c < 4; c++) lat_m[c] = 5 + 2 * c;
    @(negedge clk); start_m = 1'b1;
    @(negedge clk); start_m = 1'b0;
    cyc = 0;
    while (!(dif_m.dut_cond == 2'd2 && !dif_m.dut_start) && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check("reached_cond2_wait", 64'(dif_m.dut_cond), 64'd2);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_state("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_idle", 64'(busy_m), 64'd0);
    run_main(5, 3, 7, 9, 1'b0, 1'b0);

`ifdef BENCH_TIMEOUT_EN
    // cond1 never answers; then all silent; then a clean run clears the flag.
    run_main(5, 0, 7, 9, 1'b0, 1'b0);
    run_main(0, 0, 0, 0, 1'b0, 1'b0);
    run_main(5, 3, 7, 9, 1'b0, 1'b0);
`endif

    repeat (3) begin
      run_main(int'($urandom_range(12, 1)), int'($urandom_range(12, 1)),
               int'($urandom_range(12, 1)), int'($urandom_range(12, 1)), 1'b0, 1'b0);
    end

    // Narrow counters: cond0 totals 36 and must clamp to 31.
    run_sat(18, 3, 4, 2);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
